// File: rtl/adc_frame_writer.sv
// adc_frame_writer
// Captures a frame of 8-bit ADC samples, packs sample pairs into 16-bit
// words and queues each word with its SRAM address and bank. A four-phase
// write engine (WAIT, SETUP, STROBE, HOLD) drains the queue to SRAM while
// the display side leaves the memory free.
//
// Optional build: define FRAME_WRITER_OVF_CNT_EN to add the ovf_count
// output, a saturating count of packed words dropped on a full queue.
module adc_frame_writer #(
    parameter int LINE_PIXELS = 624,  // samples per line, even
    parameter int FRAME_LINES = 421,  // lines per frame
    parameter int FIFO_DEPTH  = 16    // queue entries, power of two, >= 2
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic        arm,
    input  logic        mem_free,
    output logic [15:0] wr_address,
    output logic [15:0] wr_data,
    output logic        wr_bank,
    output logic        wr_n,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
`ifdef FRAME_WRITER_OVF_CNT_EN
    ,
    output logic [15:0] ovf_count
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 33;  // {bank, address[15:0], data[15:0]}

    localparam logic [15:0] LAST_PIXEL = 16'(LINE_PIXELS - 1);
    localparam logic [15:0] LAST_LINE  = 16'(FRAME_LINES - 1);
    localparam logic [15:0] HALF_LINE  = 16'(LINE_PIXELS / 2);
    localparam logic [15:0] CNT_ONE    = 16'd1;
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    // Capture FSM encoding
    localparam logic [1:0] CAP_IDLE    = 2'd0;
    localparam logic [1:0] CAP_CAPTURE = 2'd1;
    localparam logic [1:0] CAP_DRAIN   = 2'd2;

    // Write engine encoding
    localparam logic [1:0] W_WAIT   = 2'd0;
    localparam logic [1:0] W_SETUP  = 2'd1;
    localparam logic [1:0] W_STROBE = 2'd2;
    localparam logic [1:0] W_HOLD   = 2'd3;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]  cap_state_q, cap_state_d;
    logic [15:0] pixel_q, pixel_d;
    logic [15:0] line_q, line_d;
    logic [7:0]  pack_q, pack_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;

    logic        arm_accept;
    logic        sample_take;
    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic [15:0] push_addr;
    logic [15:0] push_data;
    logic        push_bank;

    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;
    logic               pop;

    logic [1:0]  wr_state_q, wr_state_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_bank_q, wr_bank_d;
    logic        wr_n_q, wr_n_d;

    // ------------------------------------------------------------------
    // Queue status and the word produced by the current sample
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Odd pixel completes a word; both pixels of a pair share one address.
    assign push_req  = sample_take && pixel_q[0];
    assign push_data = {adc_data, pack_q};
    assign push_bank = line_q[0];
    // 16-bit context: the product and sum wrap modulo 2^16.
    assign push_addr = (line_q >> 1) * HALF_LINE + (pixel_q >> 1);

    // A full queue still accepts a word when the head leaves this cycle.
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Capture FSM next-state: arming, pixel/line counting, byte packing
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no
        // path through the case leaves it unassigned, which would infer a latch.
        cap_state_d  = cap_state_q;
        pixel_d      = pixel_q;
        line_d       = line_q;
        pack_d       = pack_q;
        frame_done_d = 1'b0;
        arm_accept   = 1'b0;
        sample_take  = 1'b0;

        case (cap_state_q)
            CAP_IDLE: begin
                if (arm) begin
                    cap_state_d = CAP_CAPTURE;
                    pixel_d     = '0;
                    line_d      = '0;
                    pack_d      = '0;
                    arm_accept  = 1'b1;
                end
            end

            CAP_CAPTURE: begin
                if (adc_valid) begin
                    sample_take = 1'b1;
                    if (!pixel_q[0]) begin
                        pack_d = adc_data;
                    end
                    if (pixel_q == LAST_PIXEL) begin
                        pixel_d = '0;
                        line_d  = line_q + CNT_ONE;
                        if (line_q == LAST_LINE) begin
                            cap_state_d = CAP_DRAIN;
                        end
                    end else begin
                        pixel_d = pixel_q + CNT_ONE;
                    end
                end
            end

            CAP_DRAIN: begin
                // Frame is complete only once the last word has left SRAM side.
                if (fifo_empty && (wr_state_q == W_WAIT)) begin
                    cap_state_d  = CAP_IDLE;
                    frame_done_d = 1'b1;
                end
            end

            default: begin
                cap_state_d = CAP_IDLE;
            end
        endcase
    end

    // Sticky overflow: set by a dropped word, cleared only by an accepted arm.
    always_comb begin
        if (arm_accept) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q | drop;
        end
    end

    // Capture FSM state registers
    always_ff @(posedge clk_50) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            cap_state_q  <= CAP_IDLE;
            pixel_q      <= '0;
            line_q       <= '0;
            pack_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cap_state_q  <= cap_state_d;
            pixel_q      <= pixel_d;
            line_q       <= line_d;
            pack_q       <= pack_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Word queue
    // ------------------------------------------------------------------
    // Pointer next-state: push and pop are independent
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Queue pointers; reset empties the queue
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage write port
    always_ff @(posedge clk_50) begin
        // NOTE: storage is not reset; the pointers alone define which
        // entries are valid, and an unreset array maps onto plain RAM.
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q[ADDR_W-1:0]] <= {push_bank, push_addr, push_data};
        end
    end

    // ------------------------------------------------------------------
    // Write engine: WAIT -> SETUP -> STROBE -> HOLD, one cycle each
    // ------------------------------------------------------------------
    assign pop = (wr_state_q == W_HOLD);

    // Write engine next-state and SRAM bus values
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_bank_d  = wr_bank_q;
        wr_n_d     = 1'b1;

        case (wr_state_q)
            W_WAIT: begin
                if (!fifo_empty && mem_free) begin
                    wr_state_d = W_SETUP;
                    {wr_bank_d, wr_addr_d, wr_data_d} = fifo_head;
                end
            end

            W_SETUP: begin
                // Display side grabbed the memory before the strobe: back off
                // and retry the same head word later.
                if (mem_free) begin
                    wr_state_d = W_STROBE;
                    wr_n_d     = 1'b0;
                end else begin
                    wr_state_d = W_WAIT;
                end
            end

            W_STROBE: begin
                // Once strobed, the write always completes.
                wr_state_d = W_HOLD;
            end

            W_HOLD: begin
                wr_state_d = W_WAIT;
            end

            default: begin
                wr_state_d = W_WAIT;
            end
        endcase
    end

    // Write engine registers; outputs are driven straight from flops
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            wr_state_q <= W_WAIT;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_bank_q  <= 1'b0;
            wr_n_q     <= 1'b1;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_bank_q  <= wr_bank_d;
            wr_n_q     <= wr_n_d;
        end
    end

`ifdef FRAME_WRITER_OVF_CNT_EN
    // ------------------------------------------------------------------
    // Dropped-word counter
    // ------------------------------------------------------------------
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of dropped words, cleared by an accepted arm
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (arm_accept) begin
            ovf_cnt_d = '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_ONE;
        end
    end

    // Dropped-word counter register
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_address = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = wr_bank_q;
    assign wr_n       = wr_n_q;
    assign busy       = (cap_state_q != CAP_IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_frame_writer.sv
// tb_adc_frame_writer
// Directed bench for adc_frame_writer. Instance dut uses the default
// geometry (624 x 421, 16-entry queue); instance dut_s uses a 4 x 2 frame
// so a complete capture fits in a few cycles. Inputs change on the falling
// edge; a monitor records every write strobe 1 ns after the rising edge.
module tb_adc_frame_writer;

    logic        clk_50;
    logic        rst_n;

    // Default-geometry instance
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic        arm;
    logic        mem_free;
    logic [15:0] wr_address;
    logic [15:0] wr_data;
    logic        wr_bank;
    logic        wr_n;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    // Small-frame instance
    logic [7:0]  s_adc_data;
    logic        s_adc_valid;
    logic        s_arm;
    logic        s_mem_free;
    logic [15:0] s_wr_address;
    logic [15:0] s_wr_data;
    logic        s_wr_bank;
    logic        s_wr_n;
    logic        s_busy;
    logic        s_frame_done;
    logic        s_overflow;

`ifdef FRAME_WRITER_OVF_CNT_EN
    logic [15:0] ovf_count;
    logic [15:0] s_ovf_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Recorded writes: {bank, address, data}
    logic [32:0] wq[$];
    logic [32:0] s_wq[$];
    int          fd_cnt   = 0;
    int          s_fd_cnt = 0;

    adc_frame_writer dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .arm       (arm),
        .mem_free  (mem_free),
        .wr_address(wr_address),
        .wr_data   (wr_data),
        .wr_bank   (wr_bank),
        .wr_n      (wr_n),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow)
`ifdef FRAME_WRITER_OVF_CNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    adc_frame_writer #(
        .LINE_PIXELS(4),
        .FRAME_LINES(2),
        .FIFO_DEPTH (16)
    ) dut_s (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .adc_data  (s_adc_data),
        .adc_valid (s_adc_valid),
        .arm       (s_arm),
        .mem_free  (s_mem_free),
        .wr_address(s_wr_address),
        .wr_data   (s_wr_data),
        .wr_bank   (s_wr_bank),
        .wr_n      (s_wr_n),
        .busy      (s_busy),
        .frame_done(s_frame_done),
        .overflow  (s_overflow)
`ifdef FRAME_WRITER_OVF_CNT_EN
        ,
        .ovf_count (s_ovf_count)
`endif
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // Strobe and frame_done monitor
    always @(posedge clk_50) begin
        #1;
        if (wr_n === 1'b0)         wq.push_back({wr_bank, wr_address, wr_data});
        if (s_wr_n === 1'b0)       s_wq.push_back({s_wr_bank, s_wr_address, s_wr_data});
        if (frame_done === 1'b1)   fd_cnt++;
        if (s_frame_done === 1'b1) s_fd_cnt++;
    end

    // Drive n samples (data = low byte of position) with gap idle cycles
    // between them; returns on the falling edge after the last sample.
    task automatic feed(input int start, input int n, input int gap);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50);
            v         = 16'(start + i);
            adc_valid = 1'b1;
            adc_data  = v[7:0];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk_50);
                adc_valid = 1'b0;
            end
        end
        @(negedge clk_50);
        adc_valid = 1'b0;
    endtask

    task automatic s_feed(input int start, input int n);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50);
            v           = 16'(start + i);
            s_adc_valid = 1'b1;
            s_adc_data  = v[7:0];
        end
        @(negedge clk_50);
        s_adc_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50);
        tests_run++;
        if (wr_n !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_n: got %b want 1", wr_n); end
        tests_run++;
        if (wr_address !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h want 0000", wr_address); end
        tests_run++;
        if (wr_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h want 0000", wr_data); end
        tests_run++;
        if (wr_bank !== 1'b0) begin tests_failed++; $display("FAIL reset_bank: got %b want 0", wr_bank); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tests_run++;
        if (s_wr_n !== 1'b1 || s_busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_small: got wr_n=%b busy=%b want 1/0", s_wr_n, s_busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_word;
        mem_free = 1'b1;
        @(negedge clk_50); arm = 1'b1;
        @(negedge clk_50); arm = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL arm_busy: got %b want 1", busy); end
        @(negedge clk_50); adc_valid = 1'b1; adc_data = 8'h01;
        @(negedge clk_50); adc_data = 8'h02;
        @(negedge clk_50); adc_valid = 1'b0;
        for (int i = 0; i < 20 && wq.size() < 1; i++) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 1) begin
            tests_failed++; $display("FAIL first_word_count: got %0d want 1", wq.size());
        end else if (wq[0] !== {1'b0, 16'h0000, 16'h0201}) begin
            tests_failed++; $display("FAIL first_word: got %h want %h", wq[0], {1'b0, 16'h0000, 16'h0201});
        end
        wq.delete();
    endtask

    task automatic test_line_wrap;
        // Positions 2..1249: rest of line 0, all of line 1, first pair of line 2.
        feed(2, 1248, 2);
        for (int i = 0; i < 100 && wq.size() < 624; i++) @(negedge clk_50);
        repeat (10) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 624) begin
            tests_failed++; $display("FAIL wrap_count: got %0d want 624", wq.size());
        end else begin
            tests_run++;
            if (wq[0] !== {1'b0, 16'd1, 16'h0302}) begin
                tests_failed++; $display("FAIL wrap_line0_word1: got %h want %h", wq[0], {1'b0, 16'd1, 16'h0302});
            end
            tests_run++;
            if (wq[311] !== {1'b1, 16'd0, 16'h7170}) begin
                tests_failed++; $display("FAIL wrap_line1_word0: got %h want %h", wq[311], {1'b1, 16'd0, 16'h7170});
            end
            tests_run++;
            if (wq[623] !== {1'b0, 16'd312, 16'hE1E0}) begin
                tests_failed++; $display("FAIL wrap_line2_word0: got %h want %h", wq[623], {1'b0, 16'd312, 16'hE1E0});
            end
        end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
        wq.delete();
    endtask

    task automatic test_midframe_reset;
        @(negedge clk_50); rst_n = 1'b0;
        @(negedge clk_50);
        tests_run++;
        if (busy !== 1'b0 || wr_n !== 1'b1) begin
            tests_failed++; $display("FAIL midframe_reset: got busy=%b wr_n=%b want 0/1", busy, wr_n);
        end
        tests_run++;
        if (wr_address !== 16'h0000 || wr_data !== 16'h0000) begin
            tests_failed++; $display("FAIL midframe_reset_bus: got %h/%h want 0000/0000", wr_address, wr_data);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 0) begin tests_failed++; $display("FAIL midframe_reset_flush: got %0d writes want 0", wq.size()); end
    endtask

    task automatic test_overflow;
        mem_free = 1'b0;
        @(negedge clk_50); arm = 1'b1;
        @(negedge clk_50); arm = 1'b0;
        feed(0, 34, 0);  // 17 words
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        tests_run++;
        if (wq.size() != 0) begin tests_failed++; $display("FAIL ovf_no_write: got %0d writes want 0", wq.size()); end
        mem_free = 1'b1;
        repeat (100) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 16) begin
            tests_failed++; $display("FAIL ovf_written: got %0d writes want 16", wq.size());
        end else if (wq[15] !== {1'b0, 16'd15, 16'h1F1E}) begin
            tests_failed++; $display("FAIL ovf_last_word: got %h want %h", wq[15], {1'b0, 16'd15, 16'h1F1E});
        end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
`ifdef FRAME_WRITER_OVF_CNT_EN
        tests_run++;
        if (ovf_count !== 16'd1) begin tests_failed++; $display("FAIL ovf_count: got %0d want 1", ovf_count); end
`endif
        wq.delete();
    endtask

    task automatic test_arm_ignored;
        @(negedge clk_50); arm = 1'b1;
        @(negedge clk_50); arm = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL arm_in_capture: got ovf=%b busy=%b want 1/1", overflow, busy);
        end
    endtask

    task automatic test_setup_abort;
        feed(34, 2, 0);          // word at address 17
        @(negedge clk_50);       // engine now in SETUP
        tests_run++;
        if (wr_address !== 16'd17 || wr_n !== 1'b1) begin
            tests_failed++; $display("FAIL setup_bus: got addr=%0d wr_n=%b want 17/1", wr_address, wr_n);
        end
        mem_free = 1'b0;
        repeat (8) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 0) begin tests_failed++; $display("FAIL setup_abort_strobe: got %0d writes want 0", wq.size()); end
        mem_free = 1'b1;
        repeat (10) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 1) begin
            tests_failed++; $display("FAIL setup_retry_count: got %0d writes want 1", wq.size());
        end else if (wq[0] !== {1'b0, 16'd17, 16'h2322}) begin
            tests_failed++; $display("FAIL setup_retry_word: got %h want %h", wq[0], {1'b0, 16'd17, 16'h2322});
        end
    endtask

    task automatic test_strobe_complete;
        feed(36, 2, 0);          // word at address 18
        @(negedge clk_50);       // SETUP
        @(negedge clk_50);       // STROBE
        tests_run++;
        if (wr_n !== 1'b0) begin tests_failed++; $display("FAIL strobe_low: got %b want 0", wr_n); end
        mem_free = 1'b0;
        repeat (10) @(negedge clk_50);
        mem_free = 1'b1;
        repeat (10) @(negedge clk_50);
        tests_run++;
        if (wq.size() != 2) begin
            tests_failed++; $display("FAIL strobe_complete_count: got %0d writes want 2", wq.size());
        end else if (wq[1] !== {1'b0, 16'd18, 16'h2524}) begin
            tests_failed++; $display("FAIL strobe_complete_word: got %h want %h", wq[1], {1'b0, 16'd18, 16'h2524});
        end
        wq.delete();
    endtask

    task automatic test_small_frame;
        s_mem_free = 1'b1;
        @(negedge clk_50); s_arm = 1'b1;
        @(negedge clk_50); s_arm = 1'b0;
        tests_run++;
        if (s_busy !== 1'b1) begin tests_failed++; $display("FAIL small_busy: got %b want 1", s_busy); end
        s_feed(0, 8);
        for (int i = 0; i < 100 && s_fd_cnt < 1; i++) @(negedge clk_50);
        repeat (5) @(negedge clk_50);
        tests_run++;
        if (s_fd_cnt != 1) begin tests_failed++; $display("FAIL small_frame_done_cycles: got %0d want 1", s_fd_cnt); end
        tests_run++;
        if (s_busy !== 1'b0) begin tests_failed++; $display("FAIL small_idle: got busy=%b want 0", s_busy); end
        tests_run++;
        if (s_wq.size() != 4) begin
            tests_failed++; $display("FAIL small_writes: got %0d want 4", s_wq.size());
        end else begin
            tests_run++;
            if (s_wq[1] !== {1'b0, 16'd1, 16'h0302}) begin
                tests_failed++; $display("FAIL small_word1: got %h want %h", s_wq[1], {1'b0, 16'd1, 16'h0302});
            end
            tests_run++;
            if (s_wq[2] !== {1'b1, 16'd0, 16'h0504}) begin
                tests_failed++; $display("FAIL small_word2: got %h want %h", s_wq[2], {1'b1, 16'd0, 16'h0504});
            end
            tests_run++;
            if (s_wq[3] !== {1'b1, 16'd1, 16'h0706}) begin
                tests_failed++; $display("FAIL small_word3: got %h want %h", s_wq[3], {1'b1, 16'd1, 16'h0706});
            end
        end
        s_wq.delete();
    endtask

    task automatic test_reset_strobe;
        int fd_base;
        fd_base = s_fd_cnt;
        @(negedge clk_50); s_arm = 1'b1;
        @(negedge clk_50); s_arm = 1'b0;
        s_feed(0, 2);
        @(negedge clk_50);       // SETUP
        @(negedge clk_50);       // STROBE
        tests_run++;
        if (s_wr_n !== 1'b0) begin tests_failed++; $display("FAIL rst_strobe_low: got %b want 0", s_wr_n); end
        rst_n = 1'b0;
        @(negedge clk_50);
        tests_run++;
        if (s_wr_n !== 1'b1 || s_busy !== 1'b0 || s_frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_strobe_outputs: got wr_n=%b busy=%b fd=%b want 1/0/0", s_wr_n, s_busy, s_frame_done);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk_50);
        tests_run++;
        if (s_fd_cnt != fd_base) begin tests_failed++; $display("FAIL rst_strobe_no_done: got %0d pulses want 0", s_fd_cnt - fd_base); end
        tests_run++;
        if (s_wq.size() != 1) begin tests_failed++; $display("FAIL rst_strobe_writes: got %0d want 1", s_wq.size()); end
    endtask

    initial begin
        rst_n       = 1'b0;
        adc_data    = 8'h00;
        adc_valid   = 1'b0;
        arm         = 1'b0;
        mem_free    = 1'b0;
        s_adc_data  = 8'h00;
        s_adc_valid = 1'b0;
        s_arm       = 1'b0;
        s_mem_free  = 1'b0;

        test_reset;
        test_first_word;
        test_line_wrap;
        test_midframe_reset;
        test_overflow;
        test_arm_ignored;
        test_setup_abort;
        test_strobe_complete;
        test_small_frame;
        test_reset_strobe;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adc_frame_writer.md
ADC_FRAME_WRITER -- requirements
Module: adc_frame_writer

Interface
REQ-001 Parameter LINE_PIXELS, default 624, meaning: samples per display line; SHALL be even.
REQ-002 Parameter FRAME_LINES, default 421, meaning: lines per captured frame.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning: packed-word buffer entries; SHALL be a power of 2.
REQ-004 clk_50  in  1  system clock; all logic SHALL sample on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 adc_data  in  8  ADC sample.
REQ-007 adc_valid  in  1  adc_data valid this cycle.
REQ-008 arm  in  1  starts a frame capture.
REQ-009 mem_free  in  1  high when the display side is not reading SRAM.
REQ-010 wr_address  out  16  SRAM word address.
REQ-011 wr_data  out  16  SRAM write word.
REQ-012 wr_bank  out  1  0 = low (even-line) bank, 1 = high (odd-line) bank.
REQ-013 wr_n  out  1  SRAM write strobe, active-low.
REQ-014 busy  out  1  high in CAPTURE or DRAIN.
REQ-015 frame_done  out  1  one-cycle pulse at frame completion.
REQ-016 overflow  out  1  sticky flag; a packed word was dropped.

Function
REQ-017 Capture FSM states SHALL be IDLE, CAPTURE and DRAIN.
REQ-018 arm=1 in IDLE SHALL enter CAPTURE next cycle and clear the pixel counter, line counter, pack register and overflow.
REQ-019 arm in CAPTURE or DRAIN SHALL be ignored.
REQ-020 adc_valid SHALL be ignored outside CAPTURE.
REQ-021 In CAPTURE, an even-pixel sample SHALL load byte [7:0] of the pack register; the following odd-pixel sample SHALL complete the word with byte [15:8] and push it, with its bank and address, into the FIFO.
REQ-022 Pixel counter 0..LINE_PIXELS-1 SHALL wrap to 0 and increment the line counter; bank SHALL equal line[0].
REQ-023 Word address SHALL be (line>>1)*(LINE_PIXELS/2)+(pixel>>1), computed modulo 2^16.
REQ-024 Accepting the last sample of line FRAME_LINES-1 SHALL move the FSM to DRAIN.
REQ-025 In DRAIN, once the FIFO is empty and the write engine is in WAIT, the FSM SHALL return to IDLE and pulse frame_done for one cycle.
REQ-026 Write engine states SHALL be WAIT, SETUP, STROBE and HOLD, one cycle each; with FIFO non-empty and mem_free=1, WAIT SHALL advance to SETUP.
REQ-027 SETUP: wr_address, wr_data and wr_bank SHALL be driven from the FIFO head; wr_n=1.
REQ-028 STROBE: wr_n=0. HOLD: wr_n=1 with address, data and bank held; the FIFO SHALL pop at the end of HOLD.
REQ-029 Peak write throughput SHALL be one word per 4 cycles (WAIT, SETUP, STROBE, HOLD).
REQ-030 If mem_free=0 during SETUP, the engine SHALL return to WAIT with no strobe and no pop.
REQ-031 If mem_free falls during STROBE or HOLD, the write SHALL complete normally.
REQ-032 A push while the FIFO is full SHALL drop the word and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-033 overflow SHALL stay set until the next accepted arm.

Reset
REQ-034 With rst_n=0 at a clock edge, both FSMs SHALL go to IDLE/WAIT and the FIFO SHALL empty, including mid-frame and mid-write.
REQ-035 Reset values SHALL be: wr_n=1, wr_address=0, wr_data=0, wr_bank=0, busy=0, frame_done=0, overflow=0.

Configuration
REQ-036 With FRAME_WRITER_OVF_CNT_EN defined, output ovf_count[15:0] SHALL count dropped words, saturating at 16'hFFFF, and SHALL clear on reset and on an accepted arm.
REQ-037 Without FRAME_WRITER_OVF_CNT_EN, the ovf_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-038 Reset then arm, mem_free=1, samples 8'h01,8'h02 -> one strobe with wr_address=0, wr_data=16'h0201, wr_bank=0.
REQ-039 Feed 624 samples then 2 more -> second-line word written with wr_bank=1, wr_address=0; third line's first word uses wr_bank=0, wr_address=312.
REQ-040 mem_free=0 and 17 packed words pushed -> overflow=1; the 17th word is never written; with the macro defined, ovf_count=1.
REQ-041 mem_free deasserted during SETUP -> no wr_n low and FIFO count unchanged; deasserted during STROBE -> write completes.
REQ-042 Full frame with LINE_PIXELS=4, FRAME_LINES=2 -> 4 writes, then frame_done pulses for exactly 1 cycle and busy=0.
REQ-043 rst_n=0 during STROBE -> wr_n=1 next cycle, busy=0, and no frame_done.
